// File: rtl/apb3_splitter.sv
// APB3 splitter: one upstream requester fanned out to CompletersCount
// completers, selected by the top SelBits of the address.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_paddr/psel/penable/
//   s_pwrite/pwdata            upstream request
//   s_prdata/pready/pslverr    upstream response (valid for one cycle)
//   m_paddr/penable/pwrite/
//   m_pwdata                   shared downstream request
//   m_psel                     one-hot downstream selects
//   m_prdata/pready/pslverr    per-completer responses, completer i at slice i
//   timeout_pulse              one-cycle pulse per abandoned transfer
//   timeout_count              saturating count of abandoned transfers
module apb3_splitter #(
    parameter int AddressWidth    = 20,
    parameter int DataWidth       = 32,
    parameter int CompletersCount = 4,
    parameter int TimeoutCycles   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AddressWidth-1:0]              s_paddr,
    input  logic                                 s_psel,
    input  logic                                 s_penable,
    input  logic                                 s_pwrite,
    input  logic [DataWidth-1:0]                 s_pwdata,
    output logic [DataWidth-1:0]                 s_prdata,
    output logic                                 s_pready,
    output logic                                 s_pslverr,
    output logic [AddressWidth-1:0]              m_paddr,
    output logic [CompletersCount-1:0]           m_psel,
    output logic                                 m_penable,
    output logic                                 m_pwrite,
    output logic [DataWidth-1:0]                 m_pwdata,
    input  logic [CompletersCount*DataWidth-1:0] m_prdata,
    input  logic [CompletersCount-1:0]           m_pready,
    input  logic [CompletersCount-1:0]           m_pslverr,
    output logic                                 timeout_pulse,
    output logic [7:0]                           timeout_count
);

    localparam int SelBits = $clog2(CompletersCount);

    typedef enum logic [1:0] {IDLE, DSETUP, DACCESS, RESP} state_t;

    state_t                      r_state;
    logic [SelBits-1:0]          r_idx;
    logic [7:0]                  r_tcnt;
    logic                        r_abort;
    logic [DataWidth-1:0]        r_s_prdata;
    logic                        r_s_pready;
    logic                        r_s_pslverr;
    logic [AddressWidth-1:0]     r_m_paddr;
    logic [CompletersCount-1:0]  r_m_psel;
    logic                        r_m_penable;
    logic                        r_m_pwrite;
    logic [DataWidth-1:0]        r_m_pwdata;
    logic                        r_tpulse;
    logic [7:0]                  r_tocnt;

    logic [SelBits-1:0]          w_idx;
    logic                        w_idx_ok;
    logic [CompletersCount-1:0]  w_onehot;
    logic [DataWidth-1:0]        w_rdata;
    logic                        w_rdy;
    logic                        w_err;
    logic                        w_tout;
    logic                        w_drop;

    assign w_idx    = s_paddr[AddressWidth-1 -: SelBits];
    assign w_idx_ok = int'(w_idx) < CompletersCount;
    // Timeout fires on the last allowed access cycle with no ready.
    assign w_tout   = r_tcnt == 8'(TimeoutCycles - 1);
    // Upstream gave up: finish downstream but swallow the response.
    assign w_drop   = r_abort || !s_psel;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < CompletersCount; i++) begin
            if (w_idx == SelBits'(i)) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_rdy   = 1'b0;
        w_err   = 1'b0;
        for (int i = 0; i < CompletersCount; i++) begin
            if (r_idx == SelBits'(i)) begin
                w_rdata = m_prdata[i*DataWidth +: DataWidth];
                w_rdy   = m_pready[i];
                w_err   = m_pslverr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_abort     <= 1'b0;
            r_s_prdata  <= '0;
            r_s_pready  <= 1'b0;
            r_s_pslverr <= 1'b0;
            r_m_paddr   <= '0;
            r_m_psel    <= '0;
            r_m_penable <= 1'b0;
            r_m_pwrite  <= 1'b0;
            r_m_pwdata  <= '0;
            r_tpulse    <= 1'b0;
            r_tocnt     <= '0;
        end else begin
            r_tpulse <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (s_psel && !s_penable) begin
                        if (w_idx_ok) begin
                            r_state    <= DSETUP;
                            r_idx      <= w_idx;
                            r_abort    <= 1'b0;
                            r_m_paddr  <= s_paddr;
                            r_m_pwrite <= s_pwrite;
                            r_m_pwdata <= s_pwdata;
                            r_m_psel   <= w_onehot;
                        end else begin
                            r_state     <= RESP;
                            r_s_pready  <= 1'b1;
                            r_s_prdata  <= '0;
                            r_s_pslverr <= 1'b1;
                        end
                    end
                end
                DSETUP: begin
                    r_state     <= DACCESS;
                    r_m_penable <= 1'b1;
                    r_tcnt      <= '0;
                    if (!s_psel) begin
                        r_abort <= 1'b1;
                    end
                end
                DACCESS: begin
                    r_tcnt <= r_tcnt + 8'd1;
                    if (!s_psel) begin
                        r_abort <= 1'b1;
                    end
                    if (w_rdy || w_tout) begin
                        r_m_psel    <= '0;
                        r_m_penable <= 1'b0;
                        r_m_paddr   <= '0;
                        r_m_pwrite  <= 1'b0;
                        r_m_pwdata  <= '0;
                        if (!w_rdy) begin
                            r_tpulse <= 1'b1;
                            if (r_tocnt != 8'hFF) begin
                                r_tocnt <= r_tocnt + 8'd1;
                            end
                        end
                        if (w_drop) begin
                            r_state <= IDLE;
                        end else begin
                            r_state    <= RESP;
                            r_s_pready <= 1'b1;
                            if (w_rdy) begin
                                r_s_prdata  <= r_m_pwrite ? '0 : w_rdata;
                                r_s_pslverr <= w_err;
                            end else begin
                                r_s_prdata  <= '0;
                                r_s_pslverr <= 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_s_pready  <= 1'b0;
                    r_s_prdata  <= '0;
                    r_s_pslverr <= 1'b0;
                end
            endcase
        end
    end

    assign s_prdata      = r_s_prdata;
    assign s_pready      = r_s_pready;
    assign s_pslverr     = r_s_pslverr;
    assign m_paddr       = r_m_paddr;
    assign m_psel        = r_m_psel;
    assign m_penable     = r_m_penable;
    assign m_pwrite      = r_m_pwrite;
    assign m_pwdata      = r_m_pwdata;
    assign timeout_pulse = r_tpulse;
    assign timeout_count = r_tocnt;

endmodule

// File: tb/tb_apb3_splitter.sv
// Bench for apb3_splitter: a 4-completer and a 3-completer instance share
// one upstream and completer stimulus; a per-cycle expected trace is compared.
module tb_apb3_splitter;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0]   s_paddr;
    logic            s_psel, s_penable, s_pwrite;
    logic [DW-1:0]   s_pwdata;
    logic [N*DW-1:0] m_prdata;
    logic [N-1:0]    m_pready, m_pslverr;

    logic [DW-1:0] s_prdata4, m_pwdata4, s_prdata3, m_pwdata3;
    logic          s_pready4, s_pslverr4, m_penable4, m_pwrite4, tp4;
    logic          s_pready3, s_pslverr3, m_penable3, m_pwrite3, tp3;
    logic [AW-1:0] m_paddr4, m_paddr3;
    logic [3:0]    m_psel4;
    logic [2:0]    m_psel3;
    logic [7:0]    tc4, tc3;

    apb3_splitter #(.AddressWidth(AW), .DataWidth(DW),
                    .CompletersCount(N), .TimeoutCycles(TO)) u_dut4 (
        .clk(clk), .rst(rst),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata4), .s_pready(s_pready4), .s_pslverr(s_pslverr4),
        .m_paddr(m_paddr4), .m_psel(m_psel4), .m_penable(m_penable4),
        .m_pwrite(m_pwrite4), .m_pwdata(m_pwdata4),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .timeout_pulse(tp4), .timeout_count(tc4));

    apb3_splitter #(.AddressWidth(AW), .DataWidth(DW),
                    .CompletersCount(N3), .TimeoutCycles(TO)) u_dut3 (
        .clk(clk), .rst(rst),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata3), .s_pready(s_pready3), .s_pslverr(s_pslverr3),
        .m_paddr(m_paddr3), .m_psel(m_psel3), .m_penable(m_penable3),
        .m_pwrite(m_pwrite3), .m_pwdata(m_pwdata3),
        .m_prdata(m_prdata[N3*DW-1:0]), .m_pready(m_pready[N3-1:0]),
        .m_pslverr(m_pslverr[N3-1:0]),
        .timeout_pulse(tp3), .timeout_count(tc3));

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
        logic [19:0] paddr;
        logic [3:0]  psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic        tp;
        logic [7:0]  tc;
    } exp_t;

    exp_t ex4, ex3, got4, got3;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mtc4, mtc3;

    assign got4 = {s_prdata4, s_pready4, s_pslverr4, m_paddr4, m_psel4,
                   m_penable4, m_pwrite4, m_pwdata4, tp4, tc4};
    assign got3 = {s_prdata3, s_pready3, s_pslverr3, m_paddr3, 1'b0, m_psel3,
                   m_penable3, m_pwrite3, m_pwdata3, tp3, tc3};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (got4 !== ex4) begin
                errors++;
                $display("FAIL cyc4 t=%0t got=%h exp=%h", $time, got4, ex4);
            end
            checks++;
            if (got3 !== ex3) begin
                errors++;
                $display("FAIL cyc3 t=%0t got=%h exp=%h", $time, got3, ex3);
            end
            checks++;
            if (!$onehot0(m_psel4)) begin
                errors++;
                $display("FAIL onehot got=%b exp=onehot0", m_psel4);
            end
        end
    end

    function automatic exp_t e_idle(logic [7:0] tc, logic tp);
        exp_t e = '0;
        e.tc = tc;
        e.tp = tp;
        return e;
    endfunction

    function automatic exp_t e_bus(logic [19:0] a, logic wr, logic [31:0] wd,
                                   int idx, logic en, logic [7:0] tc);
        exp_t e = '0;
        e.paddr     = a;
        e.pwrite    = wr;
        e.pwdata    = wd;
        e.psel[idx] = 1'b1;
        e.penable   = en;
        e.tc        = tc;
        return e;
    endfunction

    function automatic exp_t e_resp(logic [31:0] rd, logic er,
                                    logic [7:0] tc, logic tp);
        exp_t e = '0;
        e.prdata  = rd;
        e.pready  = 1'b1;
        e.pslverr = er;
        e.tc      = tc;
        e.tp      = tp;
        return e;
    endfunction

    function automatic logic [7:0] sat(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic lit(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        m_prdata  = {$urandom, $urandom, $urandom, $urandom};
        m_pready  = 4'($urandom);
        m_pslverr = 4'($urandom);
    endtask

    task automatic up(logic on);
        s_psel    = on;
        s_penable = on;
    endtask

    int         o_rdy_off, o_rdy_cnt, o_en_cnt, o_tp_cnt, o3_rdy_off;
    logic [31:0] o_rdata, o_pwdata;
    logic        o_err, o3_err;
    logic [3:0]  o_psel;
    logic [2:0]  o3_psel_or;
    logic [7:0]  o_tc;

    task automatic obs_clear();
        o_rdy_off = -1; o_rdy_cnt = 0; o_en_cnt = 0; o_tp_cnt = 0;
        o3_rdy_off = -1; o_rdata = 'x; o_err = 1'bx; o3_err = 1'bx;
        o_psel = '0; o_pwdata = '0; o3_psel_or = '0; o_tc = '0;
    endtask

    task automatic observe(int off);
        if (s_pready4) begin
            o_rdy_cnt++;
            o_rdy_off = off;
            o_rdata   = s_prdata4;
            o_err     = s_pslverr4;
        end
        if (m_penable4) o_en_cnt++;
        if (tp4) o_tp_cnt++;
        if (off == 1) begin
            o_psel   = m_psel4;
            o_pwdata = m_pwdata4;
        end
        o_tc = tc4;
        if (s_pready3) begin
            o3_rdy_off = off;
            o3_err     = s_pslverr3;
        end
        o3_psel_or = o3_psel_or | m_psel3;
    endtask

    // One upstream transfer. The addressed completer answers after
    // `waits` wait states; drop>=0 makes upstream abandon at that offset.
    task automatic xfer(input logic [19:0] a, input logic wr,
                        input logic [31:0] wd, input int waits,
                        input logic [31:0] rd, input logic er, input int drop);
        int  idx, nacc;
        bit  v3, tmo, dropped;
        logic [31:0] rr;
        idx = int'(a[19:18]);
        v3  = idx < N3;
        tmo = waits >= TO;
        nacc = tmo ? TO : waits + 1;
        dropped = 1'b0;
        obs_clear();
        s_psel = 1'b1; s_penable = 1'b0;
        s_paddr = a; s_pwrite = wr; s_pwdata = wd;
        junk();
        ex4 = e_idle(mtc4, 1'b0);
        ex3 = e_idle(mtc3, 1'b0);
        observe(0); tick();
        if (drop == 0) dropped = 1'b1;
        up(!dropped); junk();
        ex4 = e_bus(a, wr, wd, idx, 1'b0, mtc4);
        ex3 = v3 ? e_bus(a, wr, wd, idx, 1'b0, mtc3) : e_resp(0, 1'b1, mtc3, 1'b0);
        observe(1); tick();
        for (int k = 0; k < nacc; k++) begin
            if (drop >= 1 && k + 1 >= drop) dropped = 1'b1;
            up(!dropped); junk();
            m_pready[idx]           = (k == waits);
            m_prdata[idx*DW +: DW]  = rd;
            m_pslverr[idx]          = er;
            ex4 = e_bus(a, wr, wd, idx, 1'b1, mtc4);
            ex3 = v3 ? e_bus(a, wr, wd, idx, 1'b1, mtc3) : e_idle(mtc3, 1'b0);
            observe(2 + k); tick();
        end
        if (tmo) begin
            mtc4 = sat(mtc4);
            if (v3) mtc3 = sat(mtc3);
        end
        rr = (tmo || wr) ? 32'h0 : rd;
        up(!dropped); junk();
        if (dropped) begin
            ex4 = e_idle(mtc4, tmo);
            ex3 = e_idle(mtc3, v3 && tmo);
        end else begin
            ex4 = e_resp(rr, tmo | er, mtc4, tmo);
            ex3 = v3 ? e_resp(rr, tmo | er, mtc3, tmo) : e_idle(mtc3, 1'b0);
        end
        observe(2 + nacc); tick();
    endtask

    task automatic gap(int n);
        repeat (n) begin
            up(1'b0); junk();
            ex4 = e_idle(mtc4, 1'b0);
            ex3 = e_idle(mtc3, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [19:0] a;
        logic        wr, er;
        logic [31:0] wd, rd;
        int          waits, drop, nacc;

        rst = 1'b1;
        s_paddr = '0; s_psel = 1'b0; s_penable = 1'b0;
        s_pwrite = 1'b0; s_pwdata = '0;
        m_prdata = '0; m_pready = '0; m_pslverr = '0;
        mtc4 = '0; mtc3 = '0;
        ex4 = e_idle(8'h0, 1'b0);
        ex3 = e_idle(8'h0, 1'b0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        lit("rst_pready", {31'b0, s_pready4}, 32'h0);
        lit("rst_tcount", {24'b0, tc4}, 32'h0);
        tick();
        rst = 1'b0;

        // zero-wait read of completer 1, accepted in first cycle out of reset
        xfer(20'h40010, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, -1);
        lit("rd_psel", {28'b0, o_psel}, 32'h2);
        lit("rd_latency", 32'(o_rdy_off), 32'd3);
        lit("rd_data", o_rdata, 32'hDEADBEEF);
        lit("rd_err", {31'b0, o_err}, 32'h0);

        // write with 3 wait states, back to back
        xfer(20'hC0004, 1'b1, 32'h12345678, 3, 32'hA5A5A5A5, 1'b0, -1);
        lit("wr_pwdata", o_pwdata, 32'h12345678);
        lit("wr_en_cycles", 32'(o_en_cnt), 32'd4);
        lit("wr_err", {31'b0, o_err}, 32'h0);
        lit("wr_rdata", o_rdata, 32'h0);

        // completer error propagated
        xfer(20'h00008, 1'b0, 32'h0, 0, 32'h11112222, 1'b1, -1);
        lit("err_flag", {31'b0, o_err}, 32'h1);
        gap(1);

        // completer 2 never ready
        xfer(20'h80000, 1'b0, 32'h0, 1000, 32'h33334444, 1'b0, -1);
        lit("to_en_cycles", 32'(o_en_cnt), 32'd16);
        lit("to_err", {31'b0, o_err}, 32'h1);
        lit("to_rdata", o_rdata, 32'h0);
        lit("to_pulses", 32'(o_tp_cnt), 32'd1);
        lit("to_count", {24'b0, o_tc}, 32'd1);

        // index 3 on the 3-completer instance
        xfer(20'hC0000, 1'b0, 32'h0, 0, 32'h55556666, 1'b0, -1);
        lit("bad_latency", 32'(o3_rdy_off), 32'd1);
        lit("bad_err", {31'b0, o3_err}, 32'h1);
        lit("bad_psel", {29'b0, o3_psel_or}, 32'h0);

        // upstream abandons during setup and during access
        xfer(20'h40000, 1'b0, 32'h0, 2, 32'h77778888, 1'b0, 0);
        lit("drop0_rdy", 32'(o_rdy_cnt), 32'd0);
        xfer(20'h00000, 1'b1, 32'h9, 3, 32'h0, 1'b0, 2);
        lit("drop2_rdy", 32'(o_rdy_cnt), 32'd0);
        gap(1);

        repeat (250) begin
            a  = 20'($urandom);
            wr = 1'($urandom);
            wd = $urandom;
            rd = $urandom;
            er = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       waits = TO - 1;
                1:       waits = TO;
                2:       waits = TO + int'($urandom_range(0, 5));
                default: waits = int'($urandom_range(0, 3));
            endcase
            nacc = (waits >= TO) ? TO : waits + 1;
            drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nacc)) : -1;
            xfer(a, wr, wd, waits, rd, er, drop);
            gap(int'($urandom_range(0, 2)));
        end

        repeat (300) begin
            a = 20'h80000 | 20'($urandom_range(0, 20'h3FFFF));
            xfer(a, 1'($urandom), $urandom, TO + int'($urandom_range(0, 3)),
                 $urandom, 1'b0, -1);
        end
        lit("sat_count4", {24'b0, tc4}, 32'd255);
        lit("sat_count3", {24'b0, tc3}, 32'd255);

        // reset in the middle of an access phase
        obs_clear();
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = 20'h40000;
        s_pwrite = 1'b0; s_pwdata = 32'h0; junk();
        ex4 = e_idle(mtc4, 1'b0); ex3 = e_idle(mtc3, 1'b0);
        tick();
        up(1'b1); junk();
        ex4 = e_bus(20'h40000, 1'b0, 32'h0, 1, 1'b0, mtc4);
        ex3 = e_bus(20'h40000, 1'b0, 32'h0, 1, 1'b0, mtc3);
        tick();
        rst = 1'b1; junk(); m_pready = '0;
        ex4 = e_bus(20'h40000, 1'b0, 32'h0, 1, 1'b1, mtc4);
        ex3 = e_bus(20'h40000, 1'b0, 32'h0, 1, 1'b1, mtc3);
        tick();
        mtc4 = '0; mtc3 = '0;
        up(1'b0); junk();
        ex4 = e_idle(8'h0, 1'b0); ex3 = e_idle(8'h0, 1'b0);
        lit("rst_mid_psel", {28'b0, m_psel4}, 32'h0);
        lit("rst_mid_tcount", {24'b0, tc4}, 32'h0);
        tick();
        rst = 1'b0;
        xfer(20'h40020, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b0, -1);
        lit("post_rst_latency", 32'(o_rdy_off), 32'd3);
        lit("post_rst_data", o_rdata, 32'hCAFEF00D);
        gap(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
